multi_tap_adder: RTL and testbench



---
 rtl/multi_tap_adder.sv | 155 +++++++++++++++
 tb/tb_multi_tap_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_tap_adder.sv
// multi_tap_adder
// Streaming tap adder: sums the current sample with TAPS-1 delayed copies of
// the accepted-sample stream, spaced SPACING accepts apart. History lives in a
// circular buffer of depth (TAPS-1)*SPACING. Each tap has its own copy of that
// buffer so every copy needs only one write port and one registered read port.
// Output is registered, valid-qualified and only produced once the history
// is fully primed.

module multi_tap_adder #(
  parameter int DATA_W  = 8,
  parameter int TAPS    = 3,
  parameter int SPACING = 16,
  parameter int SIGNED  = 0,
  parameter int SUM_W   = DATA_W + $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] indata,
  input  logic              flush,
  output logic [SUM_W-1:0]  sum,
  output logic              sum_valid,
  output logic              primed
);

  // History geometry
  localparam int DEPTH  = (TAPS - 1) * SPACING;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int NRD    = TAPS - 1;

  // Operand extension to the full sum width (zero- or sign-extend)
  function automatic logic [SUM_W-1:0] extend(input logic [DATA_W-1:0] v);
    logic [SUM_W-1:0] r;
    if (SIGNED != 0) begin
      r = {{(SUM_W - DATA_W){v[DATA_W-1]}}, v};
    end else begin
      r = {{(SUM_W - DATA_W){1'b0}}, v};
    end
    return r;
  endfunction

  logic              accept;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_next;
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_next;
  logic              primed_reg;
  logic [SUM_W-1:0]  sum_reg;
  logic [SUM_W-1:0]  sum_next;
  logic              sum_valid_reg;
  logic [DATA_W-1:0] tap_data [NRD];

  // flush discards a coincident sample; rst overrides everything
  assign accept = en & ~flush & ~rst;

  // Next write pointer: cleared by rst/flush, advances (with wrap) on accept.
  // The tap read addresses are derived from this next value so that the
  // registered reads already point at the right slots for the next accept.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    if (rst || flush) begin
      wr_ptr_next = '0;
    end else if (en) begin
      if (wr_ptr_reg == PTR_W'(DEPTH - 1)) begin
        wr_ptr_next = '0;
      end else begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
    end
  end

  // Next fill count: cleared by rst/flush, saturates at DEPTH
  always_comb begin
    fill_next = fill_reg;
    if (rst || flush) begin
      fill_next = '0;
    end else if (en && (fill_reg != FILL_W'(DEPTH))) begin
      fill_next = fill_reg + FILL_W'(1);
    end
  end

  // One history copy per delayed tap
  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_tap
      localparam int OFFSET = (gi + 1) * SPACING;

      logic [DATA_W-1:0] mem [DEPTH];
      logic [PTR_W:0]    addr_wide;
      logic [PTR_W-1:0]  rd_addr;
      logic [DATA_W-1:0] rd_data_reg;

      // Read address = next pointer - OFFSET, modulo DEPTH (OFFSET <= DEPTH)
      always_comb begin
        addr_wide = {1'b0, wr_ptr_next} + (PTR_W + 1)'(DEPTH - OFFSET);
        if (addr_wide >= (PTR_W + 1)'(DEPTH)) begin
          addr_wide = addr_wide - (PTR_W + 1)'(DEPTH);
        end
        rd_addr = addr_wide[PTR_W-1:0];
      end

      // History write: only accepted samples are stored
      always_ff @(posedge clk) begin
        if (accept) begin
          mem[wr_ptr_reg] <= indata;
        end
      end

      // Registered read with forwarding of a sample written on the same edge
      // (happens when the tap distance is one accept, e.g. SPACING=1)
      always_ff @(posedge clk) begin
        if (accept && (rd_addr == wr_ptr_reg)) begin
          rd_data_reg <= indata;
        end else begin
          rd_data_reg <= mem[rd_addr];
        end
      end

      assign tap_data[gi] = rd_data_reg;
    end
  endgenerate

  // Exact tap sum: all operands extended to SUM_W before adding
  always_comb begin
    sum_next = extend(indata);
    for (int k = 0; k < NRD; k++) begin
      sum_next = sum_next + extend(tap_data[k]);
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      fill_reg      <= '0;
      primed_reg    <= 1'b0;
      sum_reg       <= '0;
      sum_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      fill_reg      <= fill_next;
      primed_reg    <= (fill_next == FILL_W'(DEPTH));
      sum_valid_reg <= 1'b0;
      if (accept && primed_reg) begin
        sum_reg       <= sum_next;
        sum_valid_reg <= 1'b1;
      end
    end
  end

  assign sum       = sum_reg;
  assign sum_valid = sum_valid_reg;
  assign primed    = primed_reg;

endmodule

// File: tb/tb_multi_tap_adder.sv
// Testbench for multi_tap_adder: three instances share one stimulus stream
// (unsigned SPACING=4, signed SPACING=4, signed SPACING=1). Expected sums
// are pushed to per-instance queues on accept; monitors pop on sum_valid.

module tb_multi_tap_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] indata = 8'd0;

  logic [9:0] sum0, sum1, sum2;
  logic       sv0, sv1, sv2;
  logic       pr0, pr1, pr2;

  always #5 clk = ~clk;

  multi_tap_adder #(.DATA_W(8), .TAPS(3), .SPACING(4), .SIGNED(0)) u_uns4 (
    .clk(clk), .rst(rst), .en(en), .indata(indata), .flush(flush),
    .sum(sum0), .sum_valid(sv0), .primed(pr0)
  );

  multi_tap_adder #(.DATA_W(8), .TAPS(3), .SPACING(4), .SIGNED(1)) u_sgn4 (
    .clk(clk), .rst(rst), .en(en), .indata(indata), .flush(flush),
    .sum(sum1), .sum_valid(sv1), .primed(pr1)
  );

  multi_tap_adder #(.DATA_W(8), .TAPS(3), .SPACING(1), .SIGNED(1)) u_sgn1 (
    .clk(clk), .rst(rst), .en(en), .indata(indata), .flush(flush),
    .sum(sum2), .sum_valid(sv2), .primed(pr2)
  );

  int checks = 0;
  int errors = 0;

  int hist[$];
  int cnt = 0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h at %0t", name, act, $time);
    end
  endtask

  // Reference: x[n] + x[n-s] + x[n-2s] from the accepted-sample history
  function automatic logic [9:0] model(input int s, input bit sg);
    int acc;
    int n;
    int v;
    acc = 0;
    n = hist.size();
    for (int k = 0; k < 3; k++) begin
      v = hist[n - 1 - k * s];
      if (sg && v >= 128) v -= 256;
      acc += v;
    end
    return acc[9:0];
  endfunction

  task automatic step(input bit e, input logic [7:0] d, input bit f = 1'b0, input bit r = 1'b0);
    @(negedge clk);
    en = e; indata = d; flush = f; rst = r;
    @(posedge clk);
    if (r) begin
      hist.delete();
      cnt = 0;
    end else if (f) begin
      hist.delete();
      cnt = 0;
    end else if (e) begin
      hist.push_back(int'(d));
      if (cnt >= 8) q0.push_back(model(4, 1'b0));
      if (cnt >= 8) q1.push_back(model(4, 1'b1));
      if (cnt >= 2) q2.push_back(model(1, 1'b1));
      if (cnt < 8) cnt++;
      if (hist.size() > 16) void'(hist.pop_front());
    end
    #1;
    chk("primed_u4", {31'd0, pr0}, {31'd0, (cnt >= 8)});
    chk("primed_s4", {31'd0, pr1}, {31'd0, (cnt >= 8)});
    chk("primed_s1", {31'd0, pr2}, {31'd0, (cnt >= 2)});
  endtask

  // Scoreboard monitors: one per instance, sampled on the falling edge
  always @(negedge clk) begin
    if (sv0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_u4: got unexpected sum_valid sum=%0h expected none", sum0);
      end else chk("sb_u4", {22'd0, sum0}, {22'd0, q0.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (sv1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_s4: got unexpected sum_valid sum=%0h expected none", sum1);
      end else chk("sb_s4", {22'd0, sum1}, {22'd0, q1.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (sv2 === 1'b1) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_s1: got unexpected sum_valid sum=%0h expected none", sum2);
      end else chk("sb_s1", {22'd0, sum2}, {22'd0, q2.pop_front()});
    end
  end

  initial begin
    // Reset state
    step(1'b0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("rst_sum", {22'd0, sum0}, 32'd0);
    chk("rst_valid", {31'd0, sv0}, 32'd0);

    // Ramp 1..12
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 8'(i));
      if (i == 9) chk("ramp_a9", {22'd0, sum0}, 32'd15);
      if (i == 10) chk("ramp_a10", {22'd0, sum0}, 32'd18);
    end
    chk("ramp_a12", {22'd0, sum0}, 32'd24);

    // Flush together with en: sample discarded, sum holds
    step(1'b1, 8'd99, 1'b1);
    chk("flush_sum_hold", {22'd0, sum0}, 32'd24);
    chk("flush_valid", {31'd0, sv0}, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 8'(100 + i));
      if (i == 8) chk("flush_a8_hold", {22'd0, sum0}, 32'd24);
    end
    chk("flush_a9", {22'd0, sum0}, 32'd315);
    chk("flush_a9_valid", {31'd0, sv0}, 32'd1);

    // Reset mid-stream with en high
    for (int i = 1; i <= 3; i++) step(1'b1, 8'(i));
    step(1'b1, 8'd50, 1'b0, 1'b1);
    chk("mid_rst_sum", {22'd0, sum0}, 32'd0);
    chk("mid_rst_valid", {31'd0, sv0}, 32'd0);
    chk("mid_rst_sum_s1", {22'd0, sum2}, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 8'(i));
      if (i == 9) chk("rerun_a9", {22'd0, sum0}, 32'd15);
      if (i == 10) chk("rerun_a10", {22'd0, sum0}, 32'd18);
    end

    // Ramp with 3 stall cycles between accepts
    step(1'b0, 8'd0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 8'(i));
      if (i == 9) chk("stall_a9", {22'd0, sum0}, 32'd15);
      for (int s = 0; s < 3; s++) begin
        step(1'b0, 8'hAA);
        if (i == 10) chk("stall_valid", {31'd0, sv0}, 32'd0);
      end
      if (i == 10) chk("stall_a10_hold", {22'd0, sum0}, 32'd18);
    end

    // Max unsigned
    step(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 8'hFF);
    chk("max_uns", {22'd0, sum0}, 32'd765);
    chk("max_as_signed", {22'd0, sum1}, 32'h3FD);

    // Most negative signed, then alternating extremes
    step(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 8'h80);
    chk("min_sgn_s4", {22'd0, sum1}, 32'h280);
    chk("min_sgn_s1", {22'd0, sum2}, 32'h280);
    chk("min_as_uns", {22'd0, sum0}, 32'h180);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, (i % 2 == 0) ? 8'h7F : 8'h80);
      if (i == 4) chk("alt_pos", {22'd0, sum2}, 32'd126);
    end
    chk("alt_neg", {22'd0, sum2}, 32'h37F);

    // Wrap: 40 continuous accepts
    step(1'b0, 8'd0, 1'b1);
    for (int i = 1; i <= 40; i++) step(1'b1, 8'(i));
    chk("wrap_a40", {22'd0, sum0}, 32'd108);

    // Drain and confirm every expected output appeared
    step(1'b0, 8'd0);
    step(1'b0, 8'd0);
    chk("drain_u4", q0.size(), 32'd0);
    chk("drain_s4", q1.size(), 32'd0);
    chk("drain_s1", q2.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
